// File: rtl/crc_word_feeder_if.sv
// Control/CRC-side bundle for crc_word_feeder.
// master drives pushes and the generator handshake, slave is the feeder.
interface crc_word_feeder_if #(
  parameter int WORD_SIZE = 32,
  parameter int DEPTH     = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                 push;
  logic [WORD_SIZE-1:0] push_data;
  logic                 flush;
  logic                 clr_overflow;
  logic                 crc_ready;
  logic [WORD_SIZE-1:0] crc_data_in;
  logic                 crc_start;
  logic                 crc_reset;
  logic [CW-1:0]        fifo_count;
  logic                 full;
  logic                 empty;
  logic                 busy;
  logic                 overflow;
  logic [15:0]          words_done;

  modport master (
    output push, push_data, flush,
    output clr_overflow, crc_ready,
    input  crc_data_in, crc_start, crc_reset,
    input  fifo_count, full, empty, busy,
    input  overflow, words_done
  );

  modport slave (
    input  push, push_data, flush,
    input  clr_overflow, crc_ready,
    output crc_data_in, crc_start, crc_reset,
    output fifo_count, full, empty, busy,
    output overflow, words_done
  );
endinterface

// File: rtl/crc_word_feeder.sv
// Word FIFO feeding a CRC generator one word per start/ready handshake.
// Head word stays in place from START until the generator completes it.
module crc_word_feeder #(
  parameter int WORD_SIZE = 32,
  parameter int DEPTH     = 4
) (
  input logic              CLK,
  input logic              RST,
  crc_word_feeder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] ACK   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

  logic [1:0]           state_q, state_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic [WORD_SIZE-1:0] mem_q [DEPTH];
  logic                 ovf_q, ovf_d;
  logic                 crst_q;
  logic [15:0]          done_q, done_d;

  logic full, empty;
  logic do_push, drop, do_pop;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  assign do_push = bus.push && !full && !bus.flush;
  assign drop    = bus.push && full && !bus.flush;
  assign do_pop  = (state_q == DONE) && bus.crc_ready
                   && !bus.flush;

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    done_d   = done_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE:    if (!empty) state_d = START;
      START:   state_d = ACK;
      ACK:     if (!bus.crc_ready) state_d = DONE;
      DONE:    if (bus.crc_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      done_d   = done_q + 16'd1;
    end

    if (do_push && !do_pop)
      count_d = count_q + CNT_ONE;
    else if (!do_push && do_pop)
      count_d = count_q - CNT_ONE;

    // a dropped push wins over a same-cycle clear
    if (drop)
      ovf_d = 1'b1;
    else if (bus.clr_overflow)
      ovf_d = 1'b0;

    if (bus.flush) begin
      state_d  = IDLE;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      done_d   = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      done_q   <= '0;
      ovf_q    <= 1'b0;
      crst_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      crst_q   <= bus.flush;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && do_push)
      mem_q[wr_ptr_q] <= bus.push_data;
  end

  assign bus.crc_data_in = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.crc_start   = (state_q == START);
  assign bus.crc_reset   = crst_q;
  assign bus.fifo_count  = count_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.busy        = (state_q != IDLE);
  assign bus.overflow    = ovf_q;
  assign bus.words_done  = done_q;
endmodule

// File: tb/tb_crc_word_feeder.sv
// Bench for crc_word_feeder: vector table, directed corner sequences
// and a random run against a queue-based reference model.
module tb_crc_word_feeder;
  localparam int WS    = 32;
  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  crc_word_feeder_if #(.WORD_SIZE(WS), .DEPTH(DEPTH)) bus();

  crc_word_feeder #(.WORD_SIZE(WS), .DEPTH(DEPTH)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct {
    int          push;
    logic [31:0] data;
    int          flush;
    int          clr;
    int          rdy;
    int          cnt;
    int          full;
    int          empty;
    int          ovf;
    int          start;
    int          crst;
    int          busy;
    int          wd;
    logic [31:0] dout;
  } vec_t;

  vec_t vec[15];

  int total = 0;
  int bad   = 0;

  logic [31:0] q[$];
  bit  m_ovf, inflight, model_en, gen_en, saw;
  int  m_wd, gen_cnt, stall, maxcnt;
  int  gen_min = 3;
  int  gen_max = 3;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // CRC generator model: drops ready for a few cycles after each start
  task automatic gen_step();
    if (bus.crc_start) begin
      gen_cnt = $urandom_range(gen_max, gen_min);
      bus.crc_ready = 1'b0;
    end else if (gen_cnt > 1) begin
      gen_cnt--;
    end else begin
      gen_cnt = 0;
      bus.crc_ready = 1'b1;
    end
  endtask

  task automatic model_step(input bit p, input logic [31:0] d,
                            input bit f, input bit c, input bit r);
    bit was_full;
    logic [31:0] head;
    was_full = (q.size() == DEPTH);
    if (f) begin
      q.delete();
      inflight = 0;
      m_wd = 0;
    end else begin
      if (inflight && r) begin
        q.delete(0);
        inflight = 0;
        m_wd = (m_wd + 1) % 65536;
      end
      if (p && !was_full) q.push_back(d);
    end
    if (p && was_full && !f) m_ovf = 1;
    else if (c) m_ovf = 0;
    head = (q.size() > 0) ? q[0] : 32'h0;

    chk("rnd_count", bus.fifo_count, q.size());
    chk("rnd_full", bus.full, q.size() == DEPTH);
    chk("rnd_empty", bus.empty, q.size() == 0);
    chk("rnd_ovf", bus.overflow, m_ovf);
    chk("rnd_wd", bus.words_done, m_wd);
    chk("rnd_data", bus.crc_data_in, head);
    chk("rnd_crst", bus.crc_reset, f);
    chk("rnd_excl", bus.crc_start & bus.crc_reset, 0);

    if (bus.crc_start) begin
      chk("rnd_start_legal", {inflight, q.size() == 0}, 0);
      inflight = 1;
      stall = 0;
    end else if (q.size() > 0 && !inflight) begin
      stall++;
      chk("rnd_start_wait", stall > 3, 0);
      if (stall > 3) stall = 0;
    end else begin
      stall = 0;
    end
  endtask

  task automatic tick();
    bit p, f, c, r;
    logic [31:0] d;
    p = bus.push;
    f = bus.flush;
    c = bus.clr_overflow;
    r = bus.crc_ready;
    d = bus.push_data;
    @(posedge CLK);
    #1;
    if (model_en) model_step(p, d, f, c, r);
    if (gen_en) gen_step();
  endtask

  task automatic do_reset(input bit rdy);
    RST = 1'b1;
    bus.push = 1'b0;
    bus.push_data = '0;
    bus.flush = 1'b0;
    bus.clr_overflow = 1'b0;
    bus.crc_ready = rdy;
    gen_cnt = 0;
    tick();
    RST = 1'b0;
    q.delete();
    inflight = 0;
    m_wd = 0;
    m_ovf = 0;
    stall = 0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, bus.fifo_count, 0);
    chk({tag, "_empty"}, bus.empty, 1);
    chk({tag, "_full"}, bus.full, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_ovf"}, bus.overflow, 0);
    chk({tag, "_wd"}, bus.words_done, 0);
    chk({tag, "_start"}, bus.crc_start, 0);
    chk({tag, "_dout"}, bus.crc_data_in, 0);
    chk({tag, "_crst"}, bus.crc_reset, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_en = 0;
    gen_en = 0;

    // reset values
    do_reset(1'b0);
    chk_reset_state("reset");
    tick();
    chk("reset_crst_drop", bus.crc_reset, 0);

    // vector table: fill to overflow, ordered drain, flush
    vec[0]  = '{1, 32'h1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h1};
    vec[1]  = '{1, 32'h2, 0, 0, 0, 2, 0, 0, 0, 1, 0, 1, 0, 32'h1};
    vec[2]  = '{1, 32'h3, 0, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0, 32'h1};
    vec[3]  = '{1, 32'h4, 0, 0, 0, 4, 1, 0, 0, 0, 0, 1, 0, 32'h1};
    vec[4]  = '{1, 32'h5, 0, 0, 0, 4, 1, 0, 1, 0, 0, 1, 0, 32'h1};
    vec[5]  = '{1, 32'h6, 0, 1, 0, 4, 1, 0, 1, 0, 0, 1, 0, 32'h1};
    vec[6]  = '{0, 32'h0, 0, 1, 0, 4, 1, 0, 0, 0, 0, 1, 0, 32'h1};
    vec[7]  = '{1, 32'h8, 0, 0, 1, 3, 0, 0, 1, 0, 0, 0, 1, 32'h2};
    vec[8]  = '{0, 32'h0, 0, 1, 1, 3, 0, 0, 0, 1, 0, 1, 1, 32'h2};
    vec[9]  = '{0, 32'h0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1, 1, 32'h2};
    vec[10] = '{0, 32'h0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1, 1, 32'h2};
    vec[11] = '{0, 32'h0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 1, 1, 32'h2};
    vec[12] = '{1, 32'h7, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 2, 32'h3};
    vec[13] = '{0, 32'h0, 1, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 32'h0};
    vec[14] = '{0, 32'h0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0};

    do_reset(1'b0);
    for (int i = 0; i < 15; i++) begin
      bus.push = vec[i].push[0];
      bus.push_data = vec[i].data;
      bus.flush = vec[i].flush[0];
      bus.clr_overflow = vec[i].clr[0];
      bus.crc_ready = vec[i].rdy[0];
      tick();
      chk($sformatf("v%0d_count", i), bus.fifo_count, vec[i].cnt);
      chk($sformatf("v%0d_full", i), bus.full, vec[i].full);
      chk($sformatf("v%0d_empty", i), bus.empty, vec[i].empty);
      chk($sformatf("v%0d_ovf", i), bus.overflow, vec[i].ovf);
      chk($sformatf("v%0d_start", i), bus.crc_start, vec[i].start);
      chk($sformatf("v%0d_crst", i), bus.crc_reset, vec[i].crst);
      chk($sformatf("v%0d_busy", i), bus.busy, vec[i].busy);
      chk($sformatf("v%0d_wd", i), bus.words_done, vec[i].wd);
      chk($sformatf("v%0d_dout", i), bus.crc_data_in, vec[i].dout);
    end
    bus.push = 0;
    bus.flush = 0;
    bus.clr_overflow = 0;

    // single word with a 3-cycle generator
    do_reset(1'b1);
    gen_en = 1;
    gen_min = 3;
    gen_max = 3;
    bus.push = 1;
    bus.push_data = 32'hDEADBEEF;
    tick();
    bus.push = 0;
    chk("single_no_start_yet", bus.crc_start, 0);
    tick();
    chk("single_start", bus.crc_start, 1);
    chk("single_data", bus.crc_data_in, 32'hDEADBEEF);
    for (int k = 0; k < 20 && bus.words_done != 16'd1; k++) tick();
    chk("single_done", bus.words_done, 1);
    chk("single_empty", bus.empty, 1);

    // pointer wrap, one push per completion
    do_reset(1'b1);
    gen_min = 2;
    gen_max = 5;
    maxcnt = 0;
    for (int i = 0; i < 10; i++) begin
      bus.push = 1;
      bus.push_data = 32'hA000 + i;
      tick();
      bus.push = 0;
      for (int k = 0; k < 10 && !bus.crc_start; k++) begin
        if (bus.fifo_count > maxcnt) maxcnt = bus.fifo_count;
        tick();
      end
      chk($sformatf("wrap%0d_start", i), bus.crc_start, 1);
      chk($sformatf("wrap%0d_data", i), bus.crc_data_in, 32'hA000 + i);
      for (int k = 0; k < 20 && bus.words_done != i + 1; k++) begin
        if (bus.fifo_count > maxcnt) maxcnt = bus.fifo_count;
        tick();
      end
      chk($sformatf("wrap%0d_wd", i), bus.words_done, i + 1);
    end
    chk("wrap_maxcnt_le1", maxcnt <= 1, 1);

    // flush while in DONE with three words queued
    gen_en = 0;
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.push = 1;
      bus.push_data = 32'hB0 + i;
      tick();
    end
    bus.push = 0;
    tick();
    chk("flush_pre_count", bus.fifo_count, 3);
    chk("flush_pre_busy", bus.busy, 1);
    bus.flush = 1;
    tick();
    bus.flush = 0;
    chk("flush_count", bus.fifo_count, 0);
    chk("flush_busy", bus.busy, 0);
    chk("flush_wd", bus.words_done, 0);
    chk("flush_crst", bus.crc_reset, 1);
    chk("flush_start", bus.crc_start, 0);
    bus.crc_ready = 1;
    tick();
    chk("flush_crst_once", bus.crc_reset, 0);
    tick();
    chk("flush_late_ready_wd", bus.words_done, 0);
    chk("flush_late_busy", bus.busy, 0);

    // reset while in ACK with two words queued
    do_reset(1'b1);
    bus.push = 1;
    bus.push_data = 32'hC1;
    tick();
    bus.push_data = 32'hC2;
    tick();
    bus.push = 0;
    tick();
    chk("rstack_pre_busy", bus.busy, 1);
    chk("rstack_pre_count", bus.fifo_count, 2);
    RST = 1;
    tick();
    RST = 0;
    chk_reset_state("rstack");
    saw = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      saw |= bus.crc_start;
    end
    chk("rstack_no_start", saw, 0);
    chk("rstack_empty", bus.empty, 1);

    // random traffic against the queue model
    do_reset(1'b1);
    gen_en = 1;
    gen_min = 2;
    gen_max = 6;
    model_en = 1;
    for (int i = 0; i < 3000; i++) begin
      bus.push = ($urandom_range(9, 0) < 4);
      bus.push_data = $urandom;
      bus.flush = ($urandom_range(99, 0) == 0);
      bus.clr_overflow = ($urandom_range(19, 0) == 0);
      tick();
    end
    bus.push = 0;
    bus.flush = 0;
    bus.clr_overflow = 0;
    model_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
